// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and helpers for the reset release sequencer
package rst_seq_pkg;
  localparam int CUR_W = 3;
  typedef enum logic [2:0] {HOLD, REL, ACK, DONE, FLT} state_e;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/sync_bit.sv
// sync_bit: DEPTH-flop single-bit synchronizer with asynchronous clear
module sync_bit #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sync_q;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) sync_q <= '0;
    else        sync_q <= {sync_q[DEPTH-2:0], d};
  assign q = sync_q[DEPTH-1];
endmodule

// File: rtl/rst_release_seq.sv
// rst_release_seq: staged per-subsystem reset release after PLL lock; RST_SEQ_TIMEOUT_EN adds ack timeout/fault
module rst_release_seq
  import rst_seq_pkg::*;
#(
  parameter int STAGES     = 4,
  parameter int SYNC_DEPTH = 2,
  parameter int LOCK_DLY   = 10,
  parameter int STAGE_DLY  = 16,
  parameter int ACK_TMO    = 200,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic [STAGES-1:0] stage_ack,
  output logic [STAGES-1:0] stage_rst_n,
  output logic              all_ready,
  output logic              fault,
  output logic [CUR_W-1:0]  cur_stage
);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_DLY - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(max3(LOCK_DLY, STAGE_DLY, ACK_TMO));
  localparam logic [CUR_W-1:0] LAST_STAGE = CUR_W'(STAGES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(ACK_TMO - 1);
`endif
  logic              srst_n, locked_s;
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_inc;
  logic [CUR_W-1:0]  cur_q;
  logic [STAGES-1:0] stage_rst_n_q, cur_bit;
  logic              all_ready_q, fault_q, ack_cur;
  sync_bit #(.DEPTH(SYNC_DEPTH)) u_rst_sync  (.clk(clk), .clr_n(rst_n), .d(1'b1),   .q(srst_n));
  sync_bit #(.DEPTH(SYNC_DEPTH)) u_lock_sync (.clk(clk), .clr_n(rst_n), .d(locked), .q(locked_s));
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  assign cur_bit = STAGES'(1) << cur_q;
  assign ack_cur = |(stage_ack & cur_bit);
  // srst_n clears asynchronously with rst_n and releases synchronously, so it is the FSM's reset
  always_ff @(posedge clk or negedge srst_n)
    if (!srst_n) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      cur_q         <= '0;
      stage_rst_n_q <= '0;
      all_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else if (!locked_s && state_q != HOLD) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      cur_q         <= '0;
      stage_rst_n_q <= '0;
      all_ready_q   <= 1'b0;
    end else begin
      case (state_q)
        HOLD:
          if (!locked_s) cnt_q <= '0;
          else if (cnt_q == LOCK_LAST) begin
            state_q <= REL;
            cnt_q   <= '0;
            cur_q   <= '0;
          end else cnt_q <= cnt_inc;
        REL: begin
          stage_rst_n_q <= stage_rst_n_q | cur_bit;
          if (cnt_q == STAGE_LAST) begin
            state_q <= ACK;
            cnt_q   <= '0;
          end else cnt_q <= cnt_inc;
        end
        ACK:
          if (ack_cur) begin
            cnt_q <= '0;
            if (cur_q == LAST_STAGE) begin
              state_q       <= DONE;
              stage_rst_n_q <= '1;
              all_ready_q   <= 1'b1;
            end else begin
              state_q <= REL;
              cur_q   <= cur_q + CUR_W'(1);
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (cnt_q == TMO_LAST) begin
            state_q       <= FLT;
            stage_rst_n_q <= '0;
            fault_q       <= 1'b1;
          end
`endif
          else cnt_q <= cnt_inc;
        default: ;
      endcase
    end
  assign stage_rst_n = stage_rst_n_q;
  assign all_ready   = all_ready_q;
  assign fault       = fault_q;
  assign cur_stage   = cur_q;
endmodule

// File: tb/tb_rst_release_seq.sv
// tb_rst_release_seq: directed checks of reset release sequencing, lock loss, timeout and async reset
module tb_rst_release_seq;
  logic       clk, rst_n, locked, all_ready, fault;
  logic [3:0] stage_ack, stage_rst_n;
  logic [2:0] cur_stage;
  int         n_tests, n_fail, cyc, n_auto;
  rst_release_seq #(
    .STAGES(4), .SYNC_DEPTH(2), .LOCK_DLY(10), .STAGE_DLY(16), .ACK_TMO(200), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .stage_ack(stage_ack),
    .stage_rst_n(stage_rst_n), .all_ready(all_ready), .fault(fault), .cur_stage(cur_stage)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // Stage k enters ACK at cycle 28+20k; its ack is raised 3 cycles later, at 31+20k.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < n_auto; k++)
        if (cyc == 31 + 20 * k) stage_ack = stage_ack | 4'(1 << k);
    end
  endtask
  task automatic tick_to(input int t);
    tick(t - cyc);
  endtask
  task automatic restart(input int n);
    rst_n = 1'b0;
    stage_ack = '0;
    locked = 1'b1;
    n_auto = 0;
    tick(3);
    n_auto = n;
    rst_n = 1'b1;
    cyc = 0;
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    n_auto = 0;
    rst_n = 1'b0;
    locked = 1'b1;
    stage_ack = '0;
    tick(3);
    check("rst_stage_rst_n", 32'(stage_rst_n), 32'h0);
    check("rst_all_ready", 32'(all_ready), 32'h0);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_cur_stage", 32'(cur_stage), 32'h0);
    // bring-up: stage 0 releases SYNC_DEPTH+LOCK_DLY+1 = 13 cycles after rst_n rises, then every 20
    restart(4);
    for (int k = 0; k < 4; k++) begin
      tick_to(12 + 20 * k);
      check("bring_pre", 32'(stage_rst_n), 32'((1 << k) - 1));
      tick_to(13 + 20 * k);
      check("bring_rel", 32'(stage_rst_n), 32'((1 << (k + 1)) - 1));
      check("bring_cur", 32'(cur_stage), 32'(k));
    end
    tick_to(91);
    check("bring_not_ready", 32'(all_ready), 32'h0);
    tick_to(92);
    check("bring_ready", 32'(all_ready), 32'h1);
    check("bring_stages", 32'(stage_rst_n), 32'hf);
    check("bring_fault", 32'(fault), 32'h0);
    // lock loss while stage 2 is in ACK (entered at cycle 68)
    restart(2);
    tick_to(70);
    check("ll_cur2", 32'(cur_stage), 32'h2);
    locked = 1'b0;
    tick_to(72);
    check("ll_still", 32'(stage_rst_n), 32'h7);
    tick_to(73);
    check("ll_drop", 32'(stage_rst_n), 32'h0);
    check("ll_cur0", 32'(cur_stage), 32'h0);
    check("ll_ready", 32'(all_ready), 32'h0);
    stage_ack = '0;
    locked = 1'b1;
    tick_to(85);
    check("ll_relock_pre", 32'(stage_rst_n), 32'h0);
    tick_to(86);
    check("ll_relock_rel", 32'(stage_rst_n), 32'h1);
    // asynchronous reset pulse in the middle of stage 3 release
    restart(4);
    tick_to(75);
    check("ar_pre", 32'(stage_rst_n), 32'hf);
    check("ar_pre_cur", 32'(cur_stage), 32'h3);
    #2;
    rst_n = 1'b0;
    stage_ack = '0;
    #1;
    check("ar_stages", 32'(stage_rst_n), 32'h0);
    check("ar_cur", 32'(cur_stage), 32'h0);
    check("ar_ready", 32'(all_ready), 32'h0);
    rst_n = 1'b1;
    cyc = 0;
    tick_to(12);
    check("ar_restart_pre", 32'(stage_rst_n), 32'h0);
    tick_to(13);
    check("ar_restart_rel", 32'(stage_rst_n), 32'h1);
    tick_to(92);
    check("ar_restart_ready", 32'(all_ready), 32'h1);
`ifdef RST_SEQ_TIMEOUT_EN
    // stage 1 never acks: ACK entered at 48, timeout 200 cycles later
    restart(1);
    tick_to(247);
    check("tmo_pre_fault", 32'(fault), 32'h0);
    check("tmo_pre_stages", 32'(stage_rst_n), 32'h3);
    tick_to(248);
    check("tmo_fault", 32'(fault), 32'h1);
    check("tmo_stages", 32'(stage_rst_n), 32'h0);
    check("tmo_ready", 32'(all_ready), 32'h0);
    tick_to(250);
    locked = 1'b0;
    tick_to(253);
    check("tmo_unlock_fault", 32'(fault), 32'h1);
    check("tmo_unlock_cur", 32'(cur_stage), 32'h0);
    locked = 1'b1;
    tick_to(266);
    check("tmo_relock_fault", 32'(fault), 32'h1);
    check("tmo_relock_rel", 32'(stage_rst_n), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("tmo_rst_fault", 32'(fault), 32'h0);
    check("tmo_rst_stages", 32'(stage_rst_n), 32'h0);
`else
    // without timeout, stage 1 waits for its ack indefinitely
    restart(1);
    tick_to(1048);
    check("nt_stages", 32'(stage_rst_n), 32'h3);
    check("nt_fault", 32'(fault), 32'h0);
    check("nt_cur", 32'(cur_stage), 32'h1);
    stage_ack = 4'hf;
    tick_to(1050);
    check("nt_rel2", 32'(stage_rst_n), 32'h7);
    tick_to(1067);
    check("nt_rel3", 32'(stage_rst_n), 32'hf);
    tick_to(1082);
    check("nt_not_ready", 32'(all_ready), 32'h0);
    tick_to(1083);
    check("nt_ready", 32'(all_ready), 32'h1);
    check("nt_fault_end", 32'(fault), 32'h0);
`endif
    // ack arrives on the would-be timeout cycle: ack wins
    restart(1);
    tick_to(247);
    stage_ack = stage_ack | 4'h2;
    tick_to(249);
    check("sc_ack_stages", 32'(stage_rst_n), 32'h7);
    check("sc_ack_fault", 32'(fault), 32'h0);
    check("sc_ack_cur", 32'(cur_stage), 32'h2);
    // locked_s falls on the same cycle stage 0's ack is sampled: lock loss wins
    restart(4);
    tick_to(29);
    locked = 1'b0;
    tick_to(31);
    check("sc_lock_pre", 32'(stage_rst_n), 32'h1);
    tick_to(33);
    check("sc_lock_stages", 32'(stage_rst_n), 32'h0);
    check("sc_lock_cur", 32'(cur_stage), 32'h0);
    check("sc_lock_ready", 32'(all_ready), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
